decoder3: RTL and testbench
===========================

Name: decoder3

Overview:
- 3-to-8 one-hot decoder used by the CPU instruction decoder to turn the 3-bit opcode field (inst[26:24]) into per-operation strobes.
- dout_0 is the add strobe; dout_7 is the jump strobe.
- Provides eight combinational outputs for the single-cycle datapath.
- Also provides a registered one-hot copy and a change strobe, for pipelined or debug use.

Parameters:
- INVERT, 0, when 1 every decoded output (dout_*, dout_q, any_q) is active-low; when 0 outputs are active-high.

Ports:
- clk  input  1  clock; all registered state updates on rising edge.
- clr_n  input  1  asynchronous, active-low reset.
- sel  input  3  opcode or select value to decode.
- en  input  1  register-update enable for the registered path; does not gate the combinational outputs.
- dout_0..dout_7  output  1 each  combinational one-hot decode of sel.
- dout_q  output  8  registered one-hot decode; bit k corresponds to sel==k.
- sel_q  output  3  registered copy of sel.
- any_q  output  1  registered valid flag; 1 once a decode has been captured since reset.
- chg  output  1  one-cycle pulse when a capture changes sel_q.

Behaviour:
- Combinational path:
  - dout_k = 1 iff sel == k, for k = 0..7.
  - Exactly one dout_* is high for any known sel value.
  - Zero latency; the path is independent of clk, clr_n and en.
  - If sel contains X or Z bits, all dout_* are 0 (inactive level).
- Registered path, asynchronous reset:
  - While clr_n = 0: dout_q = 8'h00, sel_q = 3'd0, any_q = 0, chg = 0.
  - These reset values are reached immediately, without waiting for clk.
  - Release of clr_n takes effect at the next rising edge of clk.
- Rising edge of clk with clr_n = 1 and en = 1:
  - sel_q <= sel.
  - dout_q <= one-hot(sel).
  - any_q <= 1.
  - chg <= 1 if the new sel differs from the old sel_q, or if any_q was 0 (first capture after reset); otherwise chg <= 0.
- Rising edge with en = 0:
  - sel_q, dout_q and any_q hold their values.
  - chg <= 0.
- Latency:
  - Registered outputs reflect sel one cycle after it is sampled.
  - chg is high for exactly one cycle per qualifying capture.
- Invariants:
  - After the first capture, dout_q is always exactly one-hot and equals one-hot(sel_q).
  - Before the first capture, dout_q = 0 and any_q = 0.
- Reset mid-operation:
  - An asserted clr_n overrides en and the clock.
  - The state after reset is identical to power-up.
- INVERT = 1:
  - The final output stage inverts the dout_*, dout_q and any_q bits.
  - Reset values invert accordingly: dout_q = 8'hFF, any_q = 1.
  - sel_q and chg are never inverted.
- Wrap-around: sel = 7 to sel = 0 is an ordinary transition; there is no ordering or priority.

Test Plan:
- Sweep sel 0..7 combinationally with en = 0 -> dout_k high only for k == sel (e.g. sel = 3'd7 -> only dout_7 = 1); registered outputs stay at reset values.
- Assert clr_n = 0 between clock edges after capturing sel = 5 -> dout_q = 8'h00, sel_q = 0, any_q = 0, chg = 0 immediately, without a clock edge.
- After reset release, en = 1, sel = 0 at an edge -> next cycle dout_q = 8'h01, any_q = 1, chg = 1; holding sel = 0 for another edge -> chg = 0.
- en = 1, sel sequence 2, 2, 6, 7, 0 on consecutive edges -> dout_q = 8'h04, 8'h04, 8'h40, 8'h80, 8'h01; chg = 1, 0, 1, 1, 1.
- Capture sel = 4, then en = 0 while sel changes to 1 for 3 edges -> dout_q stays 8'h10, sel_q = 4, chg = 0; dout_1 is high combinationally throughout.
- INVERT = 1 build, sel = 3 -> dout_3 = 0 and all other dout_* = 1; after reset dout_q = 8'hFF; after one capture dout_q = 8'hF7.

Source files
------------

// File: rtl/decoder3_if.sv
// Signal bundle for the 3-to-8 opcode decoder.
// master drives the select side, slave is the decoder itself.
interface decoder3_if;
    logic [2:0] sel;
    logic       en;
    logic       dout_0;
    logic       dout_1;
    logic       dout_2;
    logic       dout_3;
    logic       dout_4;
    logic       dout_5;
    logic       dout_6;
    logic       dout_7;
    logic [7:0] dout_q;
    logic [2:0] sel_q;
    logic       any_q;
    logic       chg;

    modport master (
        output sel, en,
        input  dout_0, dout_1, dout_2, dout_3,
        input  dout_4, dout_5, dout_6, dout_7,
        input  dout_q, sel_q, any_q, chg
    );

    modport slave (
        input  sel, en,
        output dout_0, dout_1, dout_2, dout_3,
        output dout_4, dout_5, dout_6, dout_7,
        output dout_q, sel_q, any_q, chg
    );
endinterface

// File: rtl/decoder3.sv
// 3-to-8 one-hot opcode decoder with a registered copy and change strobe.
// INVERT flips the polarity of every decoded output (not sel_q/chg).
module decoder3 #(
    parameter bit INVERT = 1'b0
) (
    input logic        clk,
    input logic        clr_n,
    decoder3_if.slave  bus
);

    logic [7:0] hot;
    logic [2:0] sel_q, sel_d;
    logic [7:0] hot_q, hot_d;
    logic       any_q, any_d;
    logic       chg_q, chg_d;

    // An unknown sel never matches, so every strobe stays inactive.
    always_comb begin
        hot = '0;
        for (int k = 0; k < 8; k++) begin
            if (bus.sel == 3'(k)) hot[k] = 1'b1;
        end
    end

    always_comb begin
        sel_d = sel_q;
        hot_d = hot_q;
        any_d = any_q;
        chg_d = 1'b0;
        if (bus.en) begin
            sel_d = bus.sel;
            hot_d = hot;
            any_d = 1'b1;
            chg_d = (bus.sel != sel_q) || !any_q;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sel_q <= 3'd0;
            hot_q <= 8'h00;
            any_q <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            hot_q <= hot_d;
            any_q <= any_d;
            chg_q <= chg_d;
        end
    end

    assign bus.dout_0 = hot[0] ^ INVERT;
    assign bus.dout_1 = hot[1] ^ INVERT;
    assign bus.dout_2 = hot[2] ^ INVERT;
    assign bus.dout_3 = hot[3] ^ INVERT;
    assign bus.dout_4 = hot[4] ^ INVERT;
    assign bus.dout_5 = hot[5] ^ INVERT;
    assign bus.dout_6 = hot[6] ^ INVERT;
    assign bus.dout_7 = hot[7] ^ INVERT;
    assign bus.dout_q = hot_q ^ {8{INVERT}};
    assign bus.sel_q  = sel_q;
    assign bus.any_q  = any_q ^ INVERT;
    assign bus.chg    = chg_q;

endmodule

// File: tb/tb_decoder3.sv
// Bench for decoder3: an INVERT=0 and an INVERT=1 instance share stimulus,
// checked each cycle against a behavioural model plus directed literals.
module tb_decoder3;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   run_cmp = 1'b0;

    decoder3_if bn ();
    decoder3_if bi ();

    decoder3 #(.INVERT(1'b0)) u_n (.clk(clk), .clr_n(clr_n), .bus(bn.slave));
    decoder3 #(.INVERT(1'b1)) u_i (.clk(clk), .clr_n(clr_n), .bus(bi.slave));

    always #5 clk = ~clk;

    // Model state: last captured select, whether anything was captured, strobe.
    int m_sel = 0;
    bit m_any = 1'b0;
    bit m_chg = 1'b0;

    always @(negedge clr_n) begin
        m_sel = 0;
        m_any = 1'b0;
        m_chg = 1'b0;
    end

    always @(posedge clk) begin
        if (clr_n) begin
            if (bn.en) begin
                m_chg = !m_any || (int'(bn.sel) != m_sel);
                m_sel = int'(bn.sel);
                m_any = 1'b1;
            end else begin
                m_chg = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] comb_n();
        return {bn.dout_7, bn.dout_6, bn.dout_5, bn.dout_4,
                bn.dout_3, bn.dout_2, bn.dout_1, bn.dout_0};
    endfunction

    function automatic logic [7:0] comb_i();
        return {bi.dout_7, bi.dout_6, bi.dout_5, bi.dout_4,
                bi.dout_3, bi.dout_2, bi.dout_1, bi.dout_0};
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [7:0] e_comb;
            logic [7:0] e_hot;
            e_comb = 8'h01 << bn.sel;
            e_hot  = m_any ? (8'h01 << m_sel) : 8'h00;
            check("cmp_comb", comb_n(), e_comb);
            check("cmp_comb_inv", comb_i(), ~e_comb);
            check("cmp_dout_q", bn.dout_q, e_hot);
            check("cmp_dout_q_inv", bi.dout_q, ~e_hot);
            check("cmp_sel_q", {5'd0, bn.sel_q}, 8'(m_sel));
            check("cmp_sel_q_inv", {5'd0, bi.sel_q}, 8'(m_sel));
            check("cmp_any", {7'd0, bn.any_q}, {7'd0, m_any});
            check("cmp_any_inv", {7'd0, bi.any_q}, {7'd0, !m_any});
            check("cmp_chg", {7'd0, bn.chg}, {7'd0, m_chg});
            check("cmp_chg_inv", {7'd0, bi.chg}, {7'd0, m_chg});
        end
    end

    task automatic set_in(input logic [2:0] s, input logic e);
        bn.sel = s;
        bi.sel = s;
        bn.en  = e;
        bi.en  = e;
    endtask

    task automatic step(input logic [2:0] s, input logic e);
        set_in(s, e);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 clr_n = 1'b0;
        #2 clr_n = 1'b1;
    endtask

    logic [2:0] seq_s [5] = '{3'd2, 3'd2, 3'd6, 3'd7, 3'd0};
    logic [7:0] seq_q [5] = '{8'h04, 8'h04, 8'h40, 8'h80, 8'h01};
    logic       seq_c [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        set_in(3'd0, 1'b0);
        #2;
        check("rst_dout_q", bn.dout_q, 8'h00);
        check("rst_dout_q_inv", bi.dout_q, 8'hFF);
        check("rst_any", {7'd0, bn.any_q}, 8'h00);
        check("rst_any_inv", {7'd0, bi.any_q}, 8'h01);
        run_cmp = 1'b1;
        #1 clr_n = 1'b1;

        // Combinational sweep with the register path idle.
        for (int k = 0; k < 8; k++) begin
            step(3'(k), 1'b0);
            check("sweep_comb", comb_n(), 8'h01 << k);
            check("sweep_dout_q", bn.dout_q, 8'h00);
        end
        check("sweep_sel7", comb_n(), 8'h80);

        // Capture then reset between edges.
        step(3'd5, 1'b1);
        check("cap5_dout_q", bn.dout_q, 8'h20);
        check("cap5_chg", {7'd0, bn.chg}, 8'h01);
        #2 clr_n = 1'b0;
        #1;
        check("arst_dout_q", bn.dout_q, 8'h00);
        check("arst_sel_q", {5'd0, bn.sel_q}, 8'h00);
        check("arst_any", {7'd0, bn.any_q}, 8'h00);
        check("arst_chg", {7'd0, bn.chg}, 8'h00);
        check("arst_dout_q_inv", bi.dout_q, 8'hFF);
        #2 clr_n = 1'b1;

        step(3'd0, 1'b1);
        check("first_dout_q", bn.dout_q, 8'h01);
        check("first_any", {7'd0, bn.any_q}, 8'h01);
        check("first_chg", {7'd0, bn.chg}, 8'h01);
        step(3'd0, 1'b1);
        check("hold0_chg", {7'd0, bn.chg}, 8'h00);

        for (int i = 0; i < 5; i++) begin
            step(seq_s[i], 1'b1);
            check("seq_dout_q", bn.dout_q, seq_q[i]);
            check("seq_chg", {7'd0, bn.chg}, {7'd0, seq_c[i]});
        end

        step(3'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(3'd1, 1'b0);
            check("hold_dout_q", bn.dout_q, 8'h10);
            check("hold_sel_q", {5'd0, bn.sel_q}, 8'h04);
            check("hold_chg", {7'd0, bn.chg}, 8'h00);
            check("hold_dout_1", {7'd0, bn.dout_1}, 8'h01);
        end

        // Inverted build after a fresh reset.
        pulse_reset();
        set_in(3'd3, 1'b0);
        #1;
        check("inv_comb", comb_i(), 8'hF7);
        check("inv_rst_dout_q", bi.dout_q, 8'hFF);
        step(3'd3, 1'b1);
        check("inv_cap_dout_q", bi.dout_q, 8'hF7);
        check("inv_cap_any", {7'd0, bi.any_q}, 8'h00);
        check("inv_cap_chg", {7'd0, bi.chg}, 8'h01);

        // Mixed enable pattern, checked by the per-cycle model only.
        for (int i = 0; i < 24; i++) begin
            step(3'((i * 3) % 8), 1'(i % 3 != 1));
        end
        step(3'd7, 1'b1);
        step(3'd0, 1'b1);
        check("wrap_dout_q", bn.dout_q, 8'h01);
        check("wrap_chg", {7'd0, bn.chg}, 8'h01);

        @(negedge clk);
        run_cmp = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
